// File: rtl/psum_collector.sv
// -----------------------------------------------------------------------------
// psum_collector
//
// Drains the per-column psum FIFOs of the PE-array NoC and rebuilds one output
// feature map as a single row-major valid/ready stream. Array column c holds
// output rows c, c+W, c+2W, ... with OUT_WIDTH entries per row. The collector
// reads one full row from a column, then moves to the next column in
// round-robin order. The selected column therefore always equals y mod W.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          synchronous, active-high reset
//   start_i        begin draining one frame (only sampled in IDLE)
//   psum_empty_i   per-FIFO empty flag, index 0 = array column 0
//   psum_i         first-word-fall-through head data for each FIFO
//   psum_rd_en_o   pop strobe, one-hot or zero, combinational
//   ofmap_o        output value, after optional ReLU
//   ofmap_vld_o    output valid
//   ofmap_rdy_i    downstream ready
//   ofmap_row_o    output row y of ofmap_o
//   ofmap_col_o    output column x of ofmap_o
//   ofmap_last_o   marks element (OUT_HEIGHT-1, OUT_WIDTH-1)
//   busy_o         high while draining or flushing a frame
//   done_o         one-cycle pulse when a frame has fully left the block
//   residue_err_o  sticky: some FIFO still held data at frame end
//
// OUT_HEIGHT and OUT_WIDTH must both be at least 2 so that the coordinate
// ports have a non-zero width.
// -----------------------------------------------------------------------------
module psum_collector #(
  parameter  int G_ARRAY_WIDTH  = 4,
  parameter  int G_TOP_BITS     = 2,
  parameter  int G_BOT_BITS     = 14,
  parameter  int G_KERNEL_SIZE  = 5,
  parameter  int G_IMAGE_HEIGHT = 28,
  parameter  int G_IMAGE_WIDTH  = 28,
  parameter  int G_RELU         = 0,
  localparam int DATA_WIDTH     = G_TOP_BITS + G_BOT_BITS,
  localparam int OUT_HEIGHT     = G_IMAGE_HEIGHT - G_KERNEL_SIZE + 1,
  localparam int OUT_WIDTH      = G_IMAGE_WIDTH - G_KERNEL_SIZE + 1,
  localparam int ROW_W          = $clog2(OUT_HEIGHT),
  localparam int COL_W          = $clog2(OUT_WIDTH)
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      start_i,
  input  logic [0:G_ARRAY_WIDTH-1]                  psum_empty_i,
  input  logic [0:G_ARRAY_WIDTH-1][DATA_WIDTH-1:0]  psum_i,
  output logic [0:G_ARRAY_WIDTH-1]                  psum_rd_en_o,
  output logic [DATA_WIDTH-1:0]                     ofmap_o,
  output logic                                      ofmap_vld_o,
  input  logic                                      ofmap_rdy_i,
  output logic [ROW_W-1:0]                          ofmap_row_o,
  output logic [COL_W-1:0]                          ofmap_col_o,
  output logic                                      ofmap_last_o,
  output logic                                      busy_o,
  output logic                                      done_o,
  output logic                                      residue_err_o
);

  localparam int SEL_W = (G_ARRAY_WIDTH > 1) ? $clog2(G_ARRAY_WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_FLUSH
  } state_e;

  state_e state_q, state_d;

  // Frame position of the next element to pop, and the FIFO it lives in.
  logic [COL_W-1:0] x_q;
  logic [ROW_W-1:0] y_q;
  logic [SEL_W-1:0] sel_q;

  // Output register.
  logic [DATA_WIDTH-1:0] data_q;
  logic [ROW_W-1:0]      row_q;
  logic [COL_W-1:0]      col_q;
  logic                  last_q;
  logic                  vld_q;

  logic done_q;
  logic residue_q;

  // Decoded per-cycle events.
  logic                  out_free;
  logic                  pop;
  logic                  start_ok;
  logic                  flush_ok;
  logic                  x_last;
  logic                  elem_last;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] head_relu;

  assign x_last    = (x_q == COL_W'(OUT_WIDTH - 1));
  assign elem_last = x_last && (y_q == ROW_W'(OUT_HEIGHT - 1));
  assign head      = psum_i[sel_q];
  assign head_relu = ((G_RELU != 0) && head[DATA_WIDTH-1]) ? '0 : head;

  // The output register can take a new element when it is empty or when its
  // current element is being accepted downstream in this same cycle.
  assign out_free = !vld_q || ofmap_rdy_i;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking assignments so that all
  // registers update from the same pre-edge values, regardless of block order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: each combinational block assigns a default to every output first, so
  // no path through the case statement can leave a value unassigned (latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_ok)          state_d = S_DRAIN;
      S_DRAIN: if (pop && elem_last)  state_d = S_FLUSH;
      S_FLUSH: if (flush_ok)          state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / event decode
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_o       = 1'b0;
    pop          = 1'b0;
    start_ok     = 1'b0;
    flush_ok     = 1'b0;
    psum_rd_en_o = '0;
    unique case (state_q)
      // A start that coincides with the done pulse is dropped; the next IDLE
      // cycle accepts it.
      S_IDLE: start_ok = start_i && !done_q;
      S_DRAIN: begin
        busy_o              = 1'b1;
        pop                 = !psum_empty_i[sel_q] && out_free;
        psum_rd_en_o[sel_q] = pop;
      end
      S_FLUSH: begin
        busy_o   = 1'b1;
        flush_ok = out_free;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters, output register and status flags
  // ---------------------------------------------------------------------------
  // NOTE: the output data register is reset along with its valid bit because
  // every output of the block must read zero straight after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q       <= '0;
      y_q       <= '0;
      sel_q     <= '0;
      data_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      last_q    <= 1'b0;
      vld_q     <= 1'b0;
      done_q    <= 1'b0;
      residue_q <= 1'b0;
    end else begin
      done_q <= flush_ok;

      if (start_ok) begin
        x_q       <= '0;
        y_q       <= '0;
        sel_q     <= '0;
        residue_q <= 1'b0;
      end else if (pop) begin
        if (x_last) begin
          x_q   <= '0;
          y_q   <= y_q + ROW_W'(1);
          sel_q <= (sel_q == SEL_W'(G_ARRAY_WIDTH - 1)) ? '0 : sel_q + SEL_W'(1);
        end else begin
          x_q <= x_q + COL_W'(1);
        end
      end

      if (flush_ok) begin
        residue_q <= residue_q | (|(~psum_empty_i));
      end

      // A pop always wins over a downstream accept: the register is refilled
      // rather than emptied.
      if (pop) begin
        data_q <= head_relu;
        row_q  <= y_q;
        col_q  <= x_q;
        last_q <= elem_last;
        vld_q  <= 1'b1;
      end else if (vld_q && ofmap_rdy_i) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign ofmap_o       = data_q;
  assign ofmap_vld_o   = vld_q;
  assign ofmap_row_o   = row_q;
  assign ofmap_col_o   = col_q;
  assign ofmap_last_o  = last_q;
  assign done_o        = done_q;
  assign residue_err_o = residue_q;

endmodule

// File: tb/tb_psum_collector.sv
// -----------------------------------------------------------------------------
// tb_psum_collector
//
// Two instances: the default-parameter collector fed from queue-based FIFO
// models, and a tiny 2x2-output collector with ReLU enabled for a table of
// sign/value vectors. The expected stream is the frame array that the bench
// itself builds while filling the FIFOs: element (y, x) comes from FIFO y mod W.
// -----------------------------------------------------------------------------
module tb_psum_collector;

  localparam int W  = 4;
  localparam int DW = 16;
  localparam int OH = 24;
  localparam int OW = 24;
  localparam int N  = OH * OW;
  localparam int ROWS_PER_FIFO = OH / W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals
  logic                     rst;
  logic                     start;
  logic                     rdy;
  logic [0:W-1]             empty_d;
  logic [0:W-1][DW-1:0]     psum_d;
  logic [0:W-1]             rd_en;
  logic [DW-1:0]            ofmap;
  logic                     vld;
  logic [4:0]               row;
  logic [4:0]               col;
  logic                     last;
  logic                     busy;
  logic                     done;
  logic                     res;

  // ReLU instance signals (2 FIFOs, 2x2 output)
  logic                     r_start;
  logic [0:1]               r_empty;
  logic [0:1][DW-1:0]       r_psum;
  logic [0:1]               r_rd_en;
  logic [DW-1:0]            r_ofmap;
  logic                     r_vld;
  logic                     r_rdy;
  logic [0:0]               r_row;
  logic [0:0]               r_col;
  logic                     r_last;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_res;

  psum_collector u_dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .psum_empty_i  (empty_d),
    .psum_i        (psum_d),
    .psum_rd_en_o  (rd_en),
    .ofmap_o       (ofmap),
    .ofmap_vld_o   (vld),
    .ofmap_rdy_i   (rdy),
    .ofmap_row_o   (row),
    .ofmap_col_o   (col),
    .ofmap_last_o  (last),
    .busy_o        (busy),
    .done_o        (done),
    .residue_err_o (res)
  );

  psum_collector #(
    .G_ARRAY_WIDTH  (2),
    .G_KERNEL_SIZE  (5),
    .G_IMAGE_HEIGHT (6),
    .G_IMAGE_WIDTH  (6),
    .G_RELU         (1)
  ) u_relu (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (r_start),
    .psum_empty_i  (r_empty),
    .psum_i        (r_psum),
    .psum_rd_en_o  (r_rd_en),
    .ofmap_o       (r_ofmap),
    .ofmap_vld_o   (r_vld),
    .ofmap_rdy_i   (r_rdy),
    .ofmap_row_o   (r_row),
    .ofmap_col_o   (r_col),
    .ofmap_last_o  (r_last),
    .busy_o        (r_busy),
    .done_o        (r_done),
    .residue_err_o (r_res)
  );

  typedef struct {
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
  } relu_vec_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // FIFO models and frame reference
  // ---------------------------------------------------------------------------
  logic [DW-1:0] fq [W][$];
  logic [DW-1:0] exp_val [N];
  logic [0:W-1]  hold = '0;
  bit            rnd_rdy = 1'b0;

  int out_cnt = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_pop_cyc = 0;
  int done_cyc = 0;
  int first_acc_cyc = 0;
  int last_acc_cyc = 0;

  bit            prev_stall = 1'b0;
  logic [DW-1:0] p_data;
  logic [4:0]    p_row;
  logic [4:0]    p_col;
  logic          p_last;

  task automatic clear_fifos();
    for (int c = 0; c < W; c++) fq[c].delete();
  endtask

  // Fill all FIFOs with one frame; value y*OW+x, or random when rnd is set.
  task automatic fill_frame(input bit rnd);
    logic [DW-1:0] v;
    for (int y = 0; y < OH; y++) begin
      for (int x = 0; x < OW; x++) begin
        v = rnd ? DW'($urandom) : DW'(y * OW + x);
        fq[y % W].push_back(v);
        exp_val[y * OW + x] = v;
      end
    end
  endtask

  // Pops follow the DUT's strobe at the edge where it takes effect.
  always @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < W; c++) begin
        if (rd_en[c] && fq[c].size() != 0) begin
          void'(fq[c].pop_front());
          pop_cnt++;
        end
      end
    end
  end

  // Drive FIFO heads and ready on the falling edge, then check 1 ns later.
  always @(negedge clk) begin
    logic [0:W-1] oh;
    for (int c = 0; c < W; c++) begin
      empty_d[c] = (fq[c].size() == 0) || hold[c];
      psum_d[c]  = (fq[c].size() != 0) ? fq[c][0] : '0;
    end
    rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (rd_en != '0) begin
        oh = '0;
        oh[(pop_cnt / OW) % W] = 1'b1;
        check("rd_en_sel", 32'(rd_en), 32'(oh));
        check("pop_while_stalled", 32'(vld && !rdy), 32'd0);
        last_pop_cyc = cyc;
      end
      if (prev_stall) begin
        check("hold_vld",  32'(vld),  32'd1);
        check("hold_data", 32'(ofmap), 32'(p_data));
        check("hold_row",  32'(row),  32'(p_row));
        check("hold_col",  32'(col),  32'(p_col));
        check("hold_last", 32'(last), 32'(p_last));
      end
      if (vld && rdy) begin
        if (out_cnt < N) begin
          check("out_val",  32'(ofmap), 32'(exp_val[out_cnt]));
          check("out_row",  32'(row),   32'(out_cnt / OW));
          check("out_col",  32'(col),   32'(out_cnt % OW));
          check("out_last", 32'(last),  32'(out_cnt == N - 1));
          if (out_cnt == 0)     first_acc_cyc = cyc;
          if (out_cnt == N - 1) last_acc_cyc  = cyc;
        end else begin
          check("extra_output", 32'(out_cnt), 32'(N - 1));
        end
        out_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = vld && !rdy;
      p_data = ofmap;
      p_row  = row;
      p_col  = col;
      p_last = last;
    end
  end

  task automatic start_frame();
    out_cnt  = 0;
    pop_cnt  = 0;
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (done_cnt == 0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(done_cnt != 0), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  relu_vec_t rv [8];

  initial begin
    int k;
    bit got;

    rv[0] = '{16'hC000, 16'h0000};
    rv[1] = '{16'h2000, 16'h2000};
    rv[2] = '{16'h8000, 16'h0000};
    rv[3] = '{16'h7FFF, 16'h7FFF};
    rv[4] = '{16'hFFFF, 16'h0000};
    rv[5] = '{16'h0000, 16'h0000};
    rv[6] = '{16'h0001, 16'h0001};
    rv[7] = '{16'h4000, 16'h4000};

    rst     = 1'b1;
    start   = 1'b0;
    r_start = 1'b0;
    r_empty = '1;
    r_psum  = '0;
    r_rdy   = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #2;
    // Reset state
    check("rst_vld",   32'(vld),   32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_res",   32'(res),   32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_last",  32'(last),  32'd0);
    check("rst_data",  32'(ofmap), 32'd0);
    check("rst_row",   32'(row),   32'd0);
    check("rst_col",   32'(col),   32'd0);
    check("rst_r_vld", 32'(r_vld), 32'd0);

    // Frame A: sequential data, always ready
    rnd_rdy = 1'b0;
    fill_frame(1'b0);
    start_frame();
    wait_done("A_done_seen");
    check("A_count",     32'(out_cnt), 32'(N));
    check("A_done_once", 32'(done_cnt), 32'd1);
    check("A_streak",    32'(last_acc_cyc - first_acc_cyc), 32'(N - 1));
    check("A_done_lat",  32'(done_cyc - last_pop_cyc), 32'd2);
    check("A_residue",   32'(res),  32'd0);
    check("A_idle_busy", 32'(busy), 32'd0);

    // Frame B: same data, random ready
    rnd_rdy = 1'b1;
    fill_frame(1'b0);
    start_frame();
    wait_done("B_done_seen");
    check("B_count",     32'(out_cnt), 32'(N));
    check("B_done_once", 32'(done_cnt), 32'd1);

    // Frame C: FIFO 1 held empty after row 0
    rnd_rdy = 1'b0;
    fill_frame(1'b0);
    hold = 4'b0100;
    start_frame();
    k = 0;
    while (pop_cnt < OW && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (20) @(negedge clk);
    check("C_stall_pops", 32'(pop_cnt), 32'(OW));
    check("C_fifo1_left", 32'(fq[1].size()), 32'(ROWS_PER_FIFO * OW));
    check("C_fifo2_left", 32'(fq[2].size()), 32'(ROWS_PER_FIFO * OW));
    check("C_fifo3_left", 32'(fq[3].size()), 32'(ROWS_PER_FIFO * OW));
    check("C_busy",       32'(busy), 32'd1);
    hold = '0;
    wait_done("C_done_seen");
    check("C_count", 32'(out_cnt), 32'(N));

    // Frame D: random data, negative head passed through unchanged, one extra
    // word left in FIFO 0
    rnd_rdy = 1'b1;
    fill_frame(1'b1);
    fq[0][0]   = 16'hC000;
    exp_val[0] = 16'hC000;
    fq[0].push_back(16'h1234);
    start_frame();
    wait_done("D_done_seen");
    check("D_count",   32'(out_cnt), 32'(N));
    check("D_residue", 32'(res), 32'd1);

    // Frame E: new start clears the error; reset after 100 outputs
    clear_fifos();
    fill_frame(1'b0);
    start_frame();
    #1;
    check("E_residue_clr", 32'(res),  32'd0);
    check("E_busy",        32'(busy), 32'd1);
    k = 0;
    while (out_cnt < 100 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("E_reached_100", 32'(out_cnt >= 100), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #2;
    check("E_rst_vld",   32'(vld),   32'd0);
    check("E_rst_busy",  32'(busy),  32'd0);
    check("E_rst_rd_en", 32'(rd_en), 32'd0);
    rst = 1'b0;
    clear_fifos();

    // Frame F: restart from (0,0) after reset
    fill_frame(1'b0);
    start_frame();
    wait_done("F_done_seen");
    check("F_count",     32'(out_cnt), 32'(N));
    check("F_done_once", 32'(done_cnt), 32'd1);

    // ReLU instance: table of signed inputs, two 2x2 frames
    for (int f = 0; f < 2; f++) begin
      @(negedge clk);
      r_start = 1'b1;
      @(negedge clk);
      r_start = 1'b0;
      for (int e = 0; e < 4; e++) begin
        r_psum[e / 2]  = rv[f * 4 + e].din;
        r_empty[e / 2] = 1'b0;
        got = 1'b0;
        k = 0;
        while (!got && k < 10) begin
          #1;
          got = r_rd_en[e / 2];
          if (!got) @(negedge clk);
          k++;
        end
        check("relu_pop", 32'(got), 32'd1);
        @(negedge clk);
        r_empty[e / 2] = 1'b1;
        #1;
        check("relu_vld",  32'(r_vld),   32'd1);
        check("relu_val",  32'(r_ofmap), 32'(rv[f * 4 + e].dout));
        check("relu_row",  32'(r_row),   32'(e / 2));
        check("relu_col",  32'(r_col),   32'(e % 2));
        check("relu_last", 32'(r_last),  32'(e == 3));
      end
      got = 1'b0;
      k = 0;
      while (!got && k < 10) begin
        @(negedge clk);
        #1;
        got = r_done;
        k++;
      end
      check("relu_done", 32'(got), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Drains the per-column psum output FIFOs of the PE-array NoC (first-word-fall-through, one per array column) and reassembles one output feature map as a single row-major stream.
- Array column c holds output rows c, c+W, c+2W, … with OUT_WIDTH entries per row. The collector visits columns round-robin, one full row at a time.
- Emits a valid/ready stream with row/col coordinates, optional ReLU and a last flag.
- Sits between the NoC psum FIFOs and the ofmap writeback / next-layer buffer.

Parameters:
- G_ARRAY_WIDTH, 4, number of psum FIFOs (array columns).
- G_TOP_BITS, 2, integer bits of a psum.
- G_BOT_BITS, 14, fractional bits of a psum; DATA_WIDTH = G_TOP_BITS + G_BOT_BITS.
- G_KERNEL_SIZE, 5, square kernel size.
- G_IMAGE_HEIGHT, 28, input image height; OUT_HEIGHT = G_IMAGE_HEIGHT - G_KERNEL_SIZE + 1.
- G_IMAGE_WIDTH, 28, input image width; OUT_WIDTH = G_IMAGE_WIDTH - G_KERNEL_SIZE + 1.
- G_RELU, 0, when 1, outputs with a negative two's-complement value are replaced by 0.

Ports:
- clk_i  in  1  clock. Single clock domain; all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  begin draining one frame. Sampled only in IDLE.
- psum_empty_i  in  [0:G_ARRAY_WIDTH-1]  per-FIFO empty flag.
- psum_i  in  [0:G_ARRAY_WIDTH-1][DATA_WIDTH-1:0]  FWFT FIFO head data; valid whenever the matching empty flag is 0.
- psum_rd_en_o  out  [0:G_ARRAY_WIDTH-1]  pop strobe. One-hot or zero.
- ofmap_o  out  DATA_WIDTH  output value.
- ofmap_vld_o  out  1  output valid.
- ofmap_rdy_i  in  1  downstream ready.
- ofmap_row_o  out  $clog2(OUT_HEIGHT)  output row y of ofmap_o.
- ofmap_col_o  out  $clog2(OUT_WIDTH)  output column x of ofmap_o.
- ofmap_last_o  out  1  high with element (OUT_HEIGHT-1, OUT_WIDTH-1).
- busy_o  out  1  high in DRAIN and FLUSH.
- done_o  out  1  single-cycle pulse at frame completion.
- residue_err_o  out  1  sticky error: a FIFO was non-empty at frame end. Cleared by start or reset.

Behaviour:
- Reset: state IDLE; counters x, y, sel = 0; all outputs 0.
- State IDLE:
  - busy_o = 0; psum_rd_en_o = 0.
  - On start_i = 1: clear x, y, sel and residue_err_o; go to DRAIN next cycle.
- State DRAIN, pop condition:
  - pop = !psum_empty_i[sel] && (!ofmap_vld_o || ofmap_rdy_i).
  - psum_rd_en_o[sel] = pop, combinational in the same cycle.
- State DRAIN, on pop:
  - Output register loads psum_i[sel] (after ReLU when G_RELU = 1), plus row y, col x, and last = (y == OUT_HEIGHT-1 && x == OUT_WIDTH-1).
  - ofmap_vld_o is set on the next edge.
  - Latency is 1 cycle from FIFO head to ofmap_o.
  - Full throughput of 1 element/cycle while the FIFO is non-empty and ofmap_rdy_i = 1.
- Counter advance on pop:
  - x++.
  - At x = OUT_WIDTH-1: x wraps to 0, y++, and sel = (sel+1) mod G_ARRAY_WIDTH. sel wraps from G_ARRAY_WIDTH-1 to 0, so sel always equals y mod G_ARRAY_WIDTH.
- On pop of the last element: go to FLUSH.
- Output register hold: when ofmap_vld_o = 1 and ofmap_rdy_i = 0, ofmap_o, ofmap_row_o, ofmap_col_o, ofmap_last_o and ofmap_vld_o hold, and no pop occurs.
- Output register clear: when ofmap_vld_o = 1, ofmap_rdy_i = 1 and there is no pop, ofmap_vld_o clears.
- Empty FIFO: an empty psum_empty_i[sel] stalls the collector with no timeout. Other FIFOs are never read out of order, even when non-empty.
- State FLUSH:
  - No pops.
  - When the output register is empty (or drains this cycle): done_o = 1 for one cycle; residue_err_o |= (|~psum_empty_i); go to IDLE.
- start_i outside IDLE is ignored.
- ReLU: the sign bit is psum_i[DATA_WIDTH-1]. With G_RELU = 1 and the sign bit set, the output value is all zeros. No other arithmetic is applied; width is unchanged.
- Reset mid-frame: returns to IDLE at the next edge and drops the output register contents. FIFO contents are the caller's responsibility.
- Simultaneous events:
  - Pop and downstream accept in the same cycle: the register is replaced, not cleared.
  - done_o and start_i in the same cycle: start_i is ignored. A new start is accepted in the following IDLE cycle.

Test Plan:
- Defaults (W = 4, 24x24 output), each FIFO preloaded with 6 rows x 24 values where value = y*24+x, ofmap_rdy_i = 1 -> 576 outputs in order 0..575 over 576 consecutive valid cycles. ofmap_last_o only on (23,23); done_o pulses once 2 cycles after the last pop.
- Same data, ofmap_rdy_i random 50% -> identical output sequence; outputs hold stable while stalled; psum_rd_en_o never asserted while vld = 1 and rdy = 0.
- FIFO 1 held empty for 20 cycles after row 0 completes -> no pops for those 20 cycles; resumes at (1,0) with value 24; FIFOs 2/3 untouched until their rows.
- G_RELU = 1, inputs 16'hC000 (-1.0) and 16'h2000 (0.5) -> outputs 16'h0000 and 16'h2000; with G_RELU = 0 the output is 16'hC000 unchanged.
- Extra word left in FIFO 0 after the frame -> done_o pulses and residue_err_o = 1. The next start_i clears it to 0.
- rst_i asserted after 100 outputs -> next cycle: IDLE, ofmap_vld_o = 0, busy_o = 0. After a FIFO refill and start_i, the frame restarts at (0,0).
